// File: rtl/speech256_pkg.sv
// Shared definitions for the speech256 allophone path: code width,
// dispatch FSM encoding and the pause allophone codes.
package speech256_pkg;

  localparam int ALLOPHONE_W = 6;

  // Dispatch FSM states for the queue-to-synthesizer handshake
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STROBE   = 2'd1,
    ST_WAIT_LDQ = 2'd2
  } dispatch_state_t;

  // Pause allophones (silence of increasing length)
  localparam logic [ALLOPHONE_W-1:0] PA1 = 6'h00;
  localparam logic [ALLOPHONE_W-1:0] PA2 = 6'h01;
  localparam logic [ALLOPHONE_W-1:0] PA3 = 6'h02;
  localparam logic [ALLOPHONE_W-1:0] PA4 = 6'h03;
  localparam logic [ALLOPHONE_W-1:0] PA5 = 6'h04;

  // True for any of the pause codes PA1..PA5
  function automatic logic is_pause(input logic [ALLOPHONE_W-1:0] code);
    return (code <= PA5);
  endfunction

endpackage

// File: rtl/speech256_fifo.sv
// Register-array FIFO with synchronous push/pop/flush, registered
// full/empty/count and a sticky overflow flag. DEPTH must be a power of
// two so the pointers wrap by simple overflow.
module speech256_fifo
  import speech256_pkg::*;
#(
  parameter int WIDTH = ALLOPHONE_W,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_an,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    head_reg;
  logic [AW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             overflow_reg;
  logic             push_ok;
  logic             pop_ok;

  // Full is judged on the registered count, so a write while full is
  // dropped even if a pop happens in the same cycle. Flush wins over both.
  assign push_ok = push && !full_reg && !flush;
  assign pop_ok  = pop && !empty_reg && !flush;

  // Next occupancy; full/empty are registered from this value
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else if (push_ok && !pop_ok) begin
      count_next = count_reg + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Pointers, occupancy flags and sticky overflow
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      empty_reg <= (count_next == '0);
      if (flush) begin
        head_reg     <= '0;
        tail_reg     <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (push_ok) tail_reg <= tail_reg + AW'(1);
        if (pop_ok)  head_reg <= head_reg + AW'(1);
        if (push && full_reg) overflow_reg <= 1'b1;
      end
    end
  end

  // Storage write; contents need no reset since empty gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[tail_reg] <= wr_data;
  end

  assign rd_data  = mem_reg[head_reg];
  assign full     = full_reg;
  assign empty    = empty_reg;
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/allophone_queue.sv
// Host-side allophone queue feeding a speech synthesizer. Codes written by
// the host are buffered and handed out one per ldq request with a single
// cycle data_stb; a timeout in WAIT_LDQ recovers from a stuck ldq.
module allophone_queue
  import speech256_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_an,
  input  logic [ALLOPHONE_W-1:0] wr_data,
  input  logic                   wr_en,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   ldq,
  output logic [ALLOPHONE_W-1:0] data_out,
  output logic                   data_stb
);

  // Timer counts 0..WAIT_TIMEOUT-1 while ldq stays high in WAIT_LDQ
  localparam int TW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  dispatch_state_t        state_reg;
  logic [TW-1:0]          timeout_reg;
  logic [ALLOPHONE_W-1:0] data_out_reg;
  logic                   data_stb_reg;
  logic [ALLOPHONE_W-1:0] head_data;
  logic                   fifo_empty;
  logic                   pop;

  // Pop only from IDLE on a request against a non-empty queue; a flush in
  // the same cycle cancels the pop and the FSM simply stays in IDLE.
  assign pop = (state_reg == ST_IDLE) && ldq && !fifo_empty && !flush;

  speech256_fifo #(
    .WIDTH (ALLOPHONE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_an   (rst_an),
    .push     (wr_en),
    .pop      (pop),
    .flush    (flush),
    .wr_data  (wr_data),
    .rd_data  (head_data),
    .full     (full),
    .empty    (fifo_empty),
    .count    (count),
    .overflow (overflow)
  );

  // Dispatch FSM with registered data_out/data_stb
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_reg    <= ST_IDLE;
      timeout_reg  <= '0;
      data_out_reg <= '0;
      data_stb_reg <= 1'b0;
    end else begin
      data_stb_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            data_out_reg <= head_data;
            data_stb_reg <= 1'b1;
            state_reg    <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          timeout_reg <= '0;
          state_reg   <= ST_WAIT_LDQ;
        end
        ST_WAIT_LDQ: begin
          if (!ldq) begin
            state_reg <= ST_IDLE;
          end else if (timeout_reg == TW'(WAIT_TIMEOUT - 1)) begin
            state_reg <= ST_IDLE;
          end else begin
            timeout_reg <= timeout_reg + TW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign empty    = fifo_empty;
  assign data_out = data_out_reg;
  assign data_stb = data_stb_reg;

endmodule

// File: tb/tb_allophone_queue.sv
// Self-checking bench for allophone_queue: a scoreboard queue holds the
// codes the bench expects the queue to hand out, and a negedge monitor
// compares every data_stb pulse against it.
module tb_allophone_queue;

  localparam int DEPTH = 16;
  localparam int T_OUT = 12;

  logic       clk;
  logic       rst_an;
  logic [5:0] wr_data;
  logic       wr_en;
  logic       flush;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       ldq;
  logic [5:0] data_out;
  logic       data_stb;

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] model_q [$];
  int         stb_cyc [$];
  int         stb_count = 0;
  int         cyc = 0;

  allophone_queue #(
    .DEPTH        (DEPTH),
    .WAIT_TIMEOUT (T_OUT)
  ) dut (
    .clk      (clk),
    .rst_an   (rst_an),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .flush    (flush),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .ldq      (ldq),
    .data_out (data_out),
    .data_stb (data_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one write; the bench decides acceptance from its own model
  task automatic write_code(input logic [5:0] code);
    bit accept;
    wr_data = code;
    wr_en   = 1'b1;
    accept  = (model_q.size() < DEPTH) && !flush;
    step();
    if (accept) model_q.push_back(code);
    wr_en = 1'b0;
    $display("write %02h accepted=%0d count=%0d", code, accept, count);
  endtask

  // One ldq request: strobe must follow the sampling edge by one cycle
  task automatic request_one(input string tag);
    ldq = 1'b1;
    step();
    chk({tag, "_stb"}, data_stb, 1'b1);
    ldq = 1'b0;
    step();
    chk({tag, "_stb_1cyc"}, data_stb, 1'b0);
    step();
  endtask

  // Monitor: scoreboard compare on each strobe, plus data_out hold check
  logic       prev_empty = 1'b1;
  logic       prev_rst = 1'b0;
  logic [5:0] prev_dout = '0;
  always @(negedge clk) begin
    cyc++;
    if (rst_an) begin
      if (data_stb) begin
        stb_count++;
        stb_cyc.push_back(cyc);
        chk("stb_after_empty", prev_empty, 1'b0);
        if (model_q.size() == 0) begin
          chk("sb_unexpected_stb", 0, 1);
        end else begin
          chk("sb_data", data_out, model_q.pop_front());
        end
        $display("strobe data_out=%02h cyc=%0d", data_out, cyc);
      end else if (prev_rst) begin
        chk("dout_hold", data_out, prev_dout);
      end
    end
    prev_empty = empty;
    prev_rst   = rst_an;
    prev_dout  = data_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int budget;
    rst_an  = 1'b0;
    wr_data = '0;
    wr_en   = 1'b0;
    flush   = 1'b0;
    ldq     = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_stb", data_stb, 0);
    chk("rst_dout", data_out, 0);

    // Release and write on the very first edge
    rst_an = 1'b1;
    write_code(6'h03);
    chk("first_write_count", count, 1);
    write_code(6'h1A);
    write_code(6'h2F);
    step();
    chk("three_count", count, 3);
    chk("three_empty", empty, 0);
    chk("three_no_stb", stb_count, 0);

    // Drain the three in order
    for (int i = 0; i < 3; i++) request_one("drain3");
    chk("drain3_count", count, 0);
    chk("drain3_empty", empty, 1);
    chk("drain3_nstb", stb_count, 3);

    // Fill to full, then one more
    for (int i = 0; i < 17; i++) begin
      write_code(6'((i * 3 + 1) & 63));
      if (i == 15) begin
        chk("full_at16", full, 1);
        chk("count_at16", count, 16);
        chk("ovf_at16", overflow, 0);
      end
    end
    chk("full_17", full, 1);
    chk("count_17", count, 16);
    chk("ovf_17", overflow, 1);

    // Flush with a simultaneous write: write dropped, overflow cleared
    flush   = 1'b1;
    wr_en   = 1'b1;
    wr_data = 6'h3F;
    step();
    model_q.delete();
    flush = 1'b0;
    wr_en = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_ovf", overflow, 0);
    chk("flush_empty", empty, 1);
    chk("flush_full", full, 0);

    // Flush cancels a pop requested in the same cycle
    write_code(6'h2A);
    ldq   = 1'b1;
    flush = 1'b1;
    step();
    model_q.delete();
    chk("flushpop_stb", data_stb, 0);
    chk("flushpop_count", count, 0);
    flush = 1'b0;
    ldq   = 1'b0;
    step();
    chk("flushpop_stb2", data_stb, 0);

    // Stuck ldq: second strobe after the timeout
    write_code(6'h11);
    write_code(6'h22);
    base = stb_count;
    ldq  = 1'b1;
    step();
    chk("stuck_first_stb", data_stb, 1);
    budget = 3 * T_OUT + 20;
    for (int k = 0; k < budget && stb_count < base + 2; k++) step();
    chk("stuck_two_stb", stb_count, base + 2);
    if (stb_cyc.size() >= base + 2) begin
      chk("stuck_gap", stb_cyc[base + 1] - stb_cyc[base], T_OUT + 2);
    end
    ldq = 1'b0;
    repeat (3) step();
    chk("stuck_empty", empty, 1);

    // Five queued, then 40 simultaneous push/pop pairs (pointers wrap)
    for (int i = 0; i < 5; i++) write_code(6'(i + 40));
    chk("pp_count_start", count, 5);
    for (int i = 0; i < 40; i++) begin
      wr_data = 6'((i * 7 + 11) & 63);
      wr_en   = 1'b1;
      ldq     = 1'b1;
      step();
      model_q.push_back(wr_data);
      chk("pp_stb", data_stb, 1);
      chk("pp_count", count, 5);
      wr_en = 1'b0;
      ldq   = 1'b0;
      step();
      step();
    end
    for (int i = 0; i < 5; i++) request_one("pp_drain");
    chk("pp_empty", empty, 1);

    // Reset during STROBE
    write_code(6'h05);
    write_code(6'h06);
    ldq = 1'b1;
    step();
    chk("mid_stb_before", data_stb, 1);
    #2;
    rst_an = 1'b0;
    #1;
    model_q.delete();
    chk("mid_rst_stb", data_stb, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    ldq = 1'b0;
    step();
    rst_an = 1'b1;
    write_code(6'h15);
    request_one("post_rst");
    chk("post_rst_count", count, 0);

    step();
    step();
    chk("sb_left", model_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/allophone_queue.md
ALLOPHONE_QUEUE -- requirements
Module: allophone_queue

Interface
REQ-001 Parameter DEPTH, 16, FIFO entries; SHALL be a power of two, range 2..64.
REQ-002 Parameter WAIT_TIMEOUT, 255, max cycles in WAIT_LDQ before a forced return to IDLE.
REQ-003 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst_an  input  1  reset, asynchronous, active-low.
REQ-005 wr_data  input  6  host allophone code.
REQ-006 wr_en  input  1  host write request, one entry per high cycle.
REQ-007 flush  input  1  synchronous queue clear.
REQ-008 full  output  1  high when count == DEPTH.
REQ-009 empty  output  1  high when count == 0.
REQ-010 count  output  log2(DEPTH)+1  number of stored entries.
REQ-011 overflow  output  1  sticky; set on a write attempted while full.
REQ-012 ldq  input  1  synthesizer ready-for-allophone, from the speech controller.
REQ-013 data_out  output  6  allophone code to the synthesizer data_in.
REQ-014 data_stb  output  1  one-cycle load strobe to the synthesizer data_stb.

Function
REQ-015 A write SHALL be accepted when wr_en=1, full=0 and flush=0; accepted code stored at tail, tail pointer wraps modulo DEPTH.
REQ-016 wr_en=1 with full=1 SHALL drop the write, leave contents unchanged, and set overflow.
REQ-017 full, empty and count SHALL be registered and reflect all pushes/pops of the previous edge.
REQ-018 Push and pop in the same cycle SHALL leave count unchanged; full is judged on registered count only (no write-through when full).
REQ-019 Dispatch FSM states: IDLE, STROBE, WAIT_LDQ.
REQ-020 IDLE: if ldq=1 and empty=0, SHALL pop head, load data_out with it, assert data_stb next cycle, go STROBE; otherwise stay.
REQ-021 Latency: ldq=1 with non-empty queue sampled at edge N SHALL give data_stb=1 during cycle N+1 exactly.
REQ-022 STROBE: data_stb SHALL be high for exactly one cycle; next state WAIT_LDQ; timeout counter cleared.
REQ-023 WAIT_LDQ: ldq=0 -> IDLE; ldq=1 for WAIT_TIMEOUT consecutive cycles -> IDLE (prevents double-load on a slow ldq drop and deadlock on a stuck ldq).
REQ-024 data_out SHALL hold its value from the strobe until the next strobe; it SHALL NOT change while data_stb=0.
REQ-025 flush=1 SHALL set head, tail and count to 0 and clear overflow next edge; a simultaneous wr_en SHALL be dropped without setting overflow.
REQ-026 flush SHALL NOT abort a strobe in progress or alter FSM state; a pop in the flush cycle SHALL be cancelled.
REQ-027 Pop from empty SHALL never occur; data_stb SHALL never assert with empty=1 in the preceding cycle.

Reset
REQ-028 On rst_an=0, asynchronously: head=tail=0, count=0, empty=1, full=0, overflow=0, data_out=0, data_stb=0, FSM=IDLE, timeout counter=0.
REQ-029 Reset asserted mid-strobe SHALL drop data_stb immediately; queued entries are lost.
REQ-030 After rst_an deasserts, the first write SHALL be accepted on the first clk edge.

Structure
REQ-031 Shared package speech256_pkg SHALL hold ALLOPHONE_W=6, the FSM state encoding, and the pause allophone codes (PA1..PA5).
REQ-032 Storage and pointer/count logic SHALL live in one sub-module speech256_fifo (parameterised width/depth, synchronous push/pop/flush); allophone_queue holds the dispatch FSM and timeout counter.
REQ-033 Storage SHALL be a register array, no vendor RAM macro; no combinational path from ldq to data_stb.

Verification
REQ-034 Write 0x03,0x1A,0x2F with ldq=0 -> count=3, empty=0, data_stb stays 0.
REQ-035 Then ldq=1 held 1 cycle per strobe, dropped next cycle -> three data_stb pulses, data_out 0x03,0x1A,0x2F in order, each pulse one cycle after ldq sampled high.
REQ-036 DEPTH=16: write 17 codes with ldq=0 -> full=1 after 16th, 17th dropped, overflow=1; flush -> count=0, overflow=0, empty=1.
REQ-037 ldq stuck high, 2 entries queued -> first strobe, then second strobe exactly WAIT_TIMEOUT+2 cycles later.
REQ-038 Simultaneous push and pop at count=5 -> count stays 5; wrap test: 40 push/pop pairs at DEPTH=16 -> FIFO order preserved.
REQ-039 rst_an pulsed low during STROBE -> data_stb=0 immediately, count=0, FSM IDLE; fresh write then ldq=1 -> normal strobe.
